// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshakes on both sides.
// S1 holds the preprocessed operands; S2 holds the result and its flags.
module hack_alu_pipe #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         zx,
   input  logic         nx,
   input  logic         zy,
   input  logic         ny,
   input  logic         f,
   input  logic         no,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         zr,
   output logic         ng,
   output logic         cy,
   output logic         ov
);

   logic         s1_valid_q;
   logic [N-1:0] px_q, py_q;
   logic         f_q, no_q;

   logic         out_valid_q;
   logic [N-1:0] out_q;
   logic         zr_q, ng_q, cy_q, ov_q;

   logic         s2_load;
   logic         in_xfer;
   logic [N-1:0] px_d, py_d;
   logic [N:0]   sum;
   logic [N-1:0] r;
   logic [N-1:0] res_d;
   logic         zr_d, ng_d, cy_d, ov_d;

   // in_ready depends only on state and out_ready, never on in_valid.
   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign in_xfer  = in_valid && in_ready;

   always_comb begin
      px_d = zx ? '0 : x;
      if (nx) px_d = ~px_d;
      py_d = zy ? '0 : y;
      if (ny) py_d = ~py_d;
   end

   assign sum = {1'b0, px_q} + {1'b0, py_q};

   always_comb begin
      r     = f_q ? sum[N-1:0] : (px_q & py_q);
      res_d = no_q ? ~r : r;
      cy_d  = f_q & sum[N];
      ov_d  = f_q & (px_q[N-1] == py_q[N-1]) & (r[N-1] != px_q[N-1]);
      zr_d  = (res_d == '0);
      ng_d  = res_d[N-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         px_q        <= '0;
         py_q        <= '0;
         f_q         <= 1'b0;
         no_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         zr_q        <= 1'b1;
         ng_q        <= 1'b0;
         cy_q        <= 1'b0;
         ov_q        <= 1'b0;
      end else begin
         if (in_xfer) begin
            s1_valid_q <= 1'b1;
            px_q       <= px_d;
            py_q       <= py_d;
            f_q        <= f;
            no_q       <= no;
         end else if (s2_load) begin
            s1_valid_q <= 1'b0;
         end

         if (s2_load) begin
            out_valid_q <= 1'b1;
            out_q       <= res_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            cy_q        <= cy_d;
            ov_q        <= ov_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign zr        = zr_q;
   assign ng        = ng_q;
   assign cy        = cy_q;
   assign ov        = ov_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Randomized bench for hack_alu_pipe: arithmetic reference model plus scoreboard,
// with directed cases for known results, back-pressure and reset.
module tb_hack_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] x, y, out;
   logic        zx, nx, zy, ny, f, no;
   logic        zr, ng, cy, ov;

   logic       in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0] x8, y8, out8;
   logic [5:0] c8;
   logic       zr8, ng8, cy8, ov8;

   int n_checks = 0;
   int n_fail   = 0;
   logic [19:0] exp_q[$];
   logic        hold_valid = 1'b0;
   logic [20:0] held;

   always #5 clk = ~clk;

   hack_alu_pipe #(.N(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .zr(zr), .ng(ng), .cy(cy), .ov(ov)
   );

   hack_alu_pipe #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .zx(c8[5]), .nx(c8[4]), .zy(c8[3]), .ny(c8[2]), .f(c8[1]), .no(c8[0]),
      .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
      .zr(zr8), .ng(ng8), .cy(cy8), .ov(ov8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns {out, zr, ng, cy, ov} using plain integer arithmetic.
   function automatic logic [19:0] ref_model(input logic [15:0] xv, input logic [15:0] yv,
                                             input logic [5:0] c);
      int a, b, r, sa, sb, ss;
      bit cyv, ovv;
      a = c[5] ? 0 : int'(xv);
      if (c[4]) a = 65535 - a;
      b = c[3] ? 0 : int'(yv);
      if (c[2]) b = 65535 - b;
      cyv = 1'b0;
      ovv = 1'b0;
      if (c[1]) begin
         r   = (a + b) % 65536;
         cyv = (a + b) >= 65536;
         sa  = (a >= 32768) ? a - 65536 : a;
         sb  = (b >= 32768) ? b - 65536 : b;
         ss  = sa + sb;
         ovv = (ss > 32767) || (ss < -32768);
      end else begin
         r = a & b;
      end
      if (c[0]) r = 65535 - r;
      return {r[15:0], r == 0, r >= 32768, cyv, ovv};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         hold_valid = 1'b0;
      end else begin
         if (hold_valid)
            check("hold_stable", {11'd0, out_valid, out, zr, ng, cy, ov}, {11'd0, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
            else check("result", {12'd0, out, zr, ng, cy, ov}, {12'd0, exp_q.pop_front()});
         end
         if (in_valid && in_ready)
            exp_q.push_back(ref_model(x, y, {zx, nx, zy, ny, f, no}));
         hold_valid = out_valid && !out_ready;
         held       = {1'b1, out, zr, ng, cy, ov};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
   endtask

   task automatic run_one(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic [5:0] bits, input logic [15:0] eo, input logic [3:0] ef);
      drain();
      x = xv;
      y = yv;
      {zx, nx, zy, ny, f, no} = bits;
      in_valid = 1'b1;
      #1 check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      step();
      check(tag, {11'd0, out_valid, out, zr, ng, cy, ov}, {11'd0, 1'b1, eo, ef});
   endtask

   task automatic send(input logic [15:0] xv);
      x = xv;
      y = 16'h0000;
      {zx, nx, zy, ny, f, no} = 6'b000010;
      in_valid = 1'b1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      x = 16'h1234; y = 16'h0042; {zx, nx, zy, ny, f, no} = 6'b000010;
      in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = 8'h00; y8 = 8'h00; c8 = 6'b000010;
      repeat (3) step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_state", {11'd0, out_valid, out, zr, ng, cy, ov}, {11'd0, 1'b0, 16'h0, 4'b1000});
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      step(); step();
      check("rst_no_xfer", {31'd0, out_valid}, 32'd0);

      run_one("add", 16'h0005, 16'h0003, 6'b000010, 16'h0008, 4'b0000);
      run_one("x_minus_y", 16'h0005, 16'h0003, 6'b010011, 16'h0002, 4'b0000);
      run_one("y_minus_x", 16'h0005, 16'h0003, 6'b000111, 16'hFFFE, 4'b0110);
      run_one("add_ovf", 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 4'b0101);
      run_one("add_carry", 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 4'b1010);
      run_one("const0", 16'hABCD, 16'h1234, 6'b101010, 16'h0000, 4'b1000);
      run_one("const1", 16'hABCD, 16'h1234, 6'b111111, 16'h0001, 4'b0010);
      run_one("and", 16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, 4'b0000);

      // N=8 signed overflow
      x8 = 8'h7F; y8 = 8'h01; c8 = 6'b000010; in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      step();
      check("n8_ovf", {23'd0, out_valid8, out8, zr8, ng8, cy8, ov8}, {23'd0, 1'b1, 8'h80, 4'b0101});

      // Back-pressure: three words against a stalled consumer
      drain();
      out_ready = 1'b0;
      send(16'd1);
      #1 check("bp_acc1", {31'd0, in_ready}, 32'd1);
      step(); send(16'd2);
      #1 check("bp_acc2", {31'd0, in_ready}, 32'd1);
      step(); send(16'd3);
      #1 check("bp_held_off", {31'd0, in_ready}, 32'd0);
      check("bp_first", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd1});
      step();
      #1 check("bp_held_off2", {31'd0, in_ready}, 32'd0);
      check("bp_first_stable", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd1});
      step(); out_ready = 1'b1;
      #1 check("bp_out1", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd1});
      check("bp_accept3", {31'd0, in_ready}, 32'd1);
      step(); in_valid = 1'b0;
      check("bp_out2", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd2});
      step();
      check("bp_out3", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd3});
      step();
      check("bp_empty", {31'd0, out_valid}, 32'd0);

      // Reset with two words in flight
      drain();
      out_ready = 1'b0;
      send(16'd7);
      step(); send(16'd9);
      step(); in_valid = 1'b0; rst = 1'b1;
      step(); rst = 1'b0;
      check("mid_rst", {11'd0, out_valid, out, zr, ng, cy, ov}, {11'd0, 1'b0, 16'h0, 4'b1000});
      out_ready = 1'b1;
      repeat (3) step();
      check("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);

      // Randomized traffic, occasional resets
      for (int i = 0; i < 3000; i++) begin
         step();
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         x = 16'($urandom);
         y = 16'($urandom);
         {zx, nx, zy, ny, f, no} = 6'($urandom);
      end
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      check("drain_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hack_alu_pipe.md
HACK_ALU_PIPE -- requirements
Module: hack_alu_pipe

Interface
REQ-001 Parameter: N, 16, data width in bits, N >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand/control word offered.
REQ-005 Port: in_ready  output  1  block accepts the word this cycle.
REQ-006 Port: x  input  N  first operand (D).
REQ-007 Port: y  input  N  second operand (A or M).
REQ-008 Port: zx, nx, zy, ny, f, no  input  1 each  Hack control bits.
REQ-009 Port: out_valid  output  1  result word valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port: out  output  N  result.
REQ-012 Port: zr, ng, cy, ov  output  1 each  zero, negative, carry, signed-overflow flags.

Function
REQ-013 Transfer occurs on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready, both sampled at the rising edge.
REQ-014 Two register stages SHALL exist: S1 holds the preprocessed operands px, py plus f and no; S2 holds out and the four flags.
REQ-015 Preprocessing per operand: z=0,n=0 -> operand; z=0,n=1 -> ~operand; z=1,n=0 -> all zeros; z=1,n=1 -> all ones (N bits).
REQ-016 Stage-2 core: f=1 -> r = px + py modulo 2^N; f=0 -> r = px & py; out = no ? ~r : r.
REQ-017 cy = carry out of bit N-1 of px + py when f=1; cy = 0 when f=0; no does not affect cy.
REQ-018 ov = 1 when f=1 and px[N-1] == py[N-1] and r[N-1] != px[N-1]; ov = 0 otherwise; no does not affect ov.
REQ-019 zr = 1 exactly when out is all zeros; ng = out[N-1]; both computed on the post-no value.
REQ-020 S2 loads when S1 is valid and (!out_valid || out_ready); S1 loads on input transfer.
REQ-021 in_ready = !S1_valid || S2 loads this cycle; combinational; no combinational path from in_valid to in_ready.
REQ-022 Latency: a word accepted in cycle t with out_ready held high appears with out_valid=1 in cycle t+2.
REQ-023 Throughput: one word per cycle sustained while out_ready=1.
REQ-024 Back-pressure: while out_valid=1 and out_ready=0, out and all flags SHALL hold stable; at most 2 words in flight; in_ready=0 when both stages are full and out_ready=0.
REQ-025 Simultaneous output transfer and S1-to-S2 advance in the same cycle SHALL lose no word and duplicate none.
REQ-026 Simultaneous input transfer and S1 drain SHALL replace S1 contents with the new word.
REQ-027 Ordering: results leave in acceptance order.
REQ-028 Input data and control are sampled only on transfer; changes while in_ready=0 are ignored.

Reset
REQ-029 While rst=1 at an edge: S1_valid=0, out_valid=0, out=0, zr=1, ng=0, cy=0, ov=0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-operation discards all in-flight words; no discarded word ever appears on out.
REQ-032 in_valid during rst=1 causes no transfer.

Verification
REQ-033 N=16, x=0x0005, y=0x0003, zx..no=000010, out_ready=1 -> two cycles later out=0x0008, zr=0, ng=0, cy=0, ov=0.
REQ-034 x=0x0005, y=0x0003, bits 010011 (x-y) -> out=0x0002; bits 000111 (y-x) -> out=0xFFFE, ng=1.
REQ-035 x=0x7FFF, y=0x0001, bits 000010 -> out=0x8000, ng=1, ov=1, cy=0; x=0xFFFF, y=0x0001 -> out=0x0000, zr=1, cy=1, ov=0.
REQ-036 Three back-to-back words with out_ready=0 for 4 cycles -> third word held off (in_ready=0), first result stable; after out_ready=1 all three emerge in order, one per cycle.
REQ-037 Assert rst with 2 words in flight -> next cycle out_valid=0, out=0, zr=1; no stale result after release.
REQ-038 Bits 101010 (constant 0) -> out=0x0000, zr=1; bits 111111 (constant 1) -> out=0x0001; N=8 rerun of REQ-035 with 0x7F+0x01 -> out=0x80, ov=1.
